mlp_dot_seq: RTL and testbench

Sequencer that drives the MLP multiply-accumulate unit from the controlling side. It accepts a dot-product command of length N and streams N (x, w) operand pairs from two synchronous-read memories into the MAC, asserting start on the first pair and valid on the rest. It then captures the final accumulator and emits it with a one-cycle result strobe. It sits between the layer controller (command side) and one MAC lane plus its activation and weight RAMs.

---
 rtl/mlp_pkg.sv | 21 ++
 rtl/mlp_addr_counter.sv | 38 +++
 rtl/mlp_dot_seq.sv | 156 +++++++++++++++
 tb/tb_mlp_dot_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP dot-product sequencer.
package mlp_pkg;

    localparam int A_WIDTH_DEF   = 8;
    localparam int B_WIDTH_DEF   = 8;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF = 9;

    // Cycles from the last operand read to the result strobe.
    localparam int LATENCY_EXTRA = 3;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CAPT,
        ZERO
    } state_t;

endpackage

// File: rtl/mlp_addr_counter.sv
// Loadable base+index address counter with a terminal-count flag.
module mlp_addr_counter
    import mlp_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  tc
);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  remain_reg;

    // remain_reg counts issues still to come after the current one; address wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg   <= '0;
            remain_reg <= '0;
        end else if (load) begin
            addr_reg   <= base;
            remain_reg <= len - LEN_WIDTH'(1);
        end else if (advance) begin
            addr_reg   <= addr_reg + ADDR_WIDTH'(1);
            remain_reg <= remain_reg - LEN_WIDTH'(1);
        end
    end

    assign addr = addr_reg;
    assign tc   = (remain_reg == '0);

endmodule

// File: rtl/mlp_dot_seq.sv
// Dot-product sequencer feeding one external MAC lane from two operand RAMs.
// Optional build macro: MLP_DOT_SEQ_RELU_EN (ReLU applied to the captured result).
module mlp_dot_seq
    import mlp_pkg::*;
#(
    parameter int A_WIDTH    = A_WIDTH_DEF,
    parameter int B_WIDTH    = B_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [ADDR_WIDTH-1:0] cmd_base_x,
    input  logic [ADDR_WIDTH-1:0] cmd_base_w,
    output logic                  x_rd_en,
    output logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [A_WIDTH-1:0]    x_rdata,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [B_WIDTH-1:0]    w_rdata,
    output logic                  mac_start,
    output logic                  mac_valid,
    output logic [A_WIDTH-1:0]    mac_a,
    output logic [B_WIDTH-1:0]    mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  busy
);

    state_t                 state_reg;
    logic                   rd_en_reg;
    logic                   first_reg;
    logic                   mac_start_reg;
    logic                   mac_valid_reg;
    logic                   out_valid_reg;
    logic [ACC_WIDTH-1:0]   out_data_reg;
    logic [ACC_WIDTH-1:0]   capt_data;

    logic                   accept;
    logic                   load;
    logic                   advance;
    logic                   last_issue;

    logic [1:0][ADDR_WIDTH-1:0] base_arr;
    logic [1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [1:0]                 tc_arr;

    // Ready is withheld during the result strobe so a new command starts the cycle after it.
    assign cmd_ready = (state_reg == IDLE) && !out_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign load      = accept && (cmd_len != '0);
    assign advance   = (state_reg == RUN) && !last_issue;

    assign base_arr[0] = cmd_base_x;
    assign base_arr[1] = cmd_base_w;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            mlp_addr_counter #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .LEN_WIDTH  (LEN_WIDTH)
            ) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .load    (load),
                .advance (advance),
                .base    (base_arr[gi]),
                .len     (cmd_len),
                .addr    (addr_arr[gi]),
                .tc      (tc_arr[gi])
            );
        end
    endgenerate

    // Both counters run in lockstep, so either terminal count marks the final issue.
    assign last_issue = &tc_arr;

`ifdef MLP_DOT_SEQ_RELU_EN
    assign capt_data = mac_result[ACC_WIDTH-1] ? '0 : mac_result;
`else
    assign capt_data = mac_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rd_en_reg     <= 1'b0;
            first_reg     <= 1'b0;
            mac_start_reg <= 1'b0;
            mac_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            // MAC strobes follow the read by one cycle, matching the RAM read latency.
            mac_start_reg <= rd_en_reg && first_reg;
            mac_valid_reg <= rd_en_reg && !first_reg;
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (cmd_len != '0) begin
                            state_reg <= RUN;
                            rd_en_reg <= 1'b1;
                            first_reg <= 1'b1;
                        end else begin
                            state_reg <= ZERO;
                        end
                    end
                end
                RUN: begin
                    first_reg <= 1'b0;
                    if (last_issue) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_reg <= CAPT;
                end
                CAPT: begin
                    out_data_reg  <= capt_data;
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                ZERO: begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    rd_en_reg <= 1'b0;
                    first_reg <= 1'b0;
                end
            endcase
        end
    end

    assign x_rd_en   = rd_en_reg;
    assign w_rd_en   = rd_en_reg;
    assign x_addr    = addr_arr[0];
    assign w_addr    = addr_arr[1];
    assign mac_start = mac_start_reg;
    assign mac_valid = mac_valid_reg;
    assign mac_a     = x_rdata;
    assign mac_b     = w_rdata;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mlp_dot_seq.sv
// Self-checking bench for mlp_dot_seq with RAM and MAC models and a dot-product reference.
module tb_mlp_dot_seq;
    import mlp_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [8:0]         cmd_len = '0;
    logic [7:0]         cmd_base_x = '0;
    logic [7:0]         cmd_base_w = '0;
    logic               x_rd_en, w_rd_en;
    logic [7:0]         x_addr, w_addr;
    logic signed [7:0]  x_q = '0;
    logic signed [7:0]  w_q = '0;
    logic               mac_start, mac_valid;
    logic signed [7:0]  mac_a, mac_b;
    int                 acc = 0;
    int                 prod;
    logic               out_valid;
    logic [31:0]        out_data;
    logic               busy;

    logic signed [7:0]  xmem [256];
    logic signed [7:0]  wmem [256];

    // Per-cycle observation record, indexed by cycle relative to a command acceptance.
    bit                 r_rd [64];
    bit                 r_st [64];
    bit                 r_vl [64];
    bit                 r_ov [64];
    bit                 r_rdy [64];
    bit                 r_bz [64];
    bit                 r_acc [64];
    logic [7:0]         r_xa [64];
    logic [7:0]         r_wa [64];
    logic [31:0]        r_od [64];

    int errors = 0;
    int checks = 0;

    mlp_dot_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_base_x (cmd_base_x),
        .cmd_base_w (cmd_base_w),
        .x_rd_en    (x_rd_en),
        .x_addr     (x_addr),
        .x_rdata    (x_q),
        .w_rd_en    (w_rd_en),
        .w_addr     (w_addr),
        .w_rdata    (w_q),
        .mac_start  (mac_start),
        .mac_valid  (mac_valid),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_result (acc),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_rd_en) x_q <= xmem[x_addr];
        if (w_rd_en) w_q <= wmem[w_addr];
    end

    always_comb prod = int'(mac_a) * int'(mac_b);

    always @(posedge clk) begin
        if (mac_start)      acc <= prod;
        else if (mac_valid) acc <= acc + prod;
    end

    function automatic int relu_if(input int v);
`ifdef MLP_DOT_SEQ_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int dot_ref(input int len, input int bx, input int bw);
        int sum = 0;
        for (int i = 0; i < len; i++)
            sum += int'(xmem[(bx + i) % 256]) * int'(wmem[(bw + i) % 256]);
        return relu_if(sum);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input int len, input int bx, input int bw);
        int w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_len    = 9'(len);
        cmd_base_x = 8'(bx);
        cmd_base_w = 8'(bw);
    endtask

    task automatic obs(input int n, input int drop_k, input int chg_k, input int len2,
                       input int bx2, input int bw2, input int rst_k);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            r_rd[k]  = x_rd_en;
            r_st[k]  = mac_start;
            r_vl[k]  = mac_valid;
            r_ov[k]  = out_valid;
            r_rdy[k] = cmd_ready;
            r_bz[k]  = busy;
            r_acc[k] = cmd_valid && cmd_ready;
            r_xa[k]  = x_addr;
            r_wa[k]  = w_addr;
            r_od[k]  = out_data;
            if (k == drop_k) cmd_valid = 1'b0;
            if (k == chg_k) begin
                cmd_len    = 9'(len2);
                cmd_base_x = 8'(bx2);
                cmd_base_w = 8'(bw2);
            end
            if (rst_k >= 0) rst = (k == rst_k);
        end
    endtask

    task automatic check_cmd(input string tag, input int len, input int bx, input int bw, input int off);
        int nrd = 0, addr_err = 0, nst = 0, st_cyc = -1, nvl = 0, vl_err = 0, ov_cyc = -1, k;
        logic [31:0] ov_data = '0;
        int expv;
        for (int c = off + 1; c <= off + len + LATENCY_EXTRA; c++) begin
            k = c - off;
            if (r_rd[c]) begin
                nrd++;
                if (k < 1 || k > len || r_xa[c] != 8'(bx + k - 1) || r_wa[c] != 8'(bw + k - 1))
                    addr_err++;
            end
            if (r_st[c]) begin
                nst++;
                st_cyc = k;
                if (r_vl[c]) vl_err++;
            end
            if (r_vl[c]) begin
                nvl++;
                if (k < 3 || k > len + 1) vl_err++;
            end
            if (r_ov[c] && ov_cyc < 0) begin
                ov_cyc  = k;
                ov_data = r_od[c];
            end
        end
        expv = dot_ref(len, bx, bw);
        check({tag, "_reads"}, nrd, len);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_n_start"}, nst, (len > 0) ? 1 : 0);
        check({tag, "_start_cyc"}, st_cyc, (len > 0) ? 2 : -1);
        check({tag, "_n_valid"}, nvl, (len > 0) ? len - 1 : 0);
        check({tag, "_valid_err"}, vl_err, 0);
        check({tag, "_out_cyc"}, ov_cyc, (len > 0) ? len + LATENCY_EXTRA : 2);
        check({tag, "_out_data"}, $signed(ov_data), expv);
        $display("cmd %s len=%0d bx=%0d bw=%0d out_cyc=%0d out_data=%0d ref=%0d",
                 tag, len, bx, bw, ov_cyc, $signed(ov_data), expv);
    endtask

    initial begin
        int len, bx, bw, acc2, ov_late;
        for (int i = 0; i < 256; i++) begin
            xmem[i] = 8'($urandom);
            wmem[i] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", {x_rd_en, w_rd_en}, 0);
        check("rst_mac", {mac_start, mac_valid}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_addr", {x_addr, w_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Small known dot product.
        xmem[0] = 8'sd1; xmem[1] = 8'sd2; xmem[2] = 8'sd3;
        wmem[0] = 8'sd4; wmem[1] = 8'sd5; wmem[2] = 8'sd6;
        start_cmd(3, 0, 0);
        obs(10, 1, -1, 0, 0, 0, -1);
        check_cmd("n3", 3, 0, 0, 0);
        check("n3_literal", $signed(r_od[6]), relu_if(32));

        // Extreme negative product pair.
        xmem[100] = -8'sd128; xmem[101] = -8'sd128;
        wmem[100] = 8'sd127;  wmem[101] = 8'sd127;
        start_cmd(2, 100, 100);
        obs(9, 1, -1, 0, 0, 0, -1);
        check_cmd("neg", 2, 100, 100, 0);
        check("neg_literal", $signed(r_od[5]), relu_if(-32512));

        // Zero-length command.
        start_cmd(0, 7, 9);
        obs(6, 1, -1, 0, 0, 0, -1);
        check_cmd("len0", 0, 7, 9, 0);

        // Address wrap.
        start_cmd(3, 255, 254);
        obs(10, 1, -1, 0, 0, 0, -1);
        check_cmd("wrap", 3, 255, 254, 0);

        // Back-to-back with cmd_valid held; fields change while busy.
        start_cmd(4, 10, 20);
        obs(20, 9, 1, 4, 40, 60, -1);
        acc2 = -1;
        for (int k = 1; k < 20; k++)
            if (r_acc[k] && acc2 < 0) acc2 = k;
        check("b2b_accept2", acc2, 8);
        check_cmd("b2b_1", 4, 10, 20, 0);
        check_cmd("b2b_2", 4, 40, 60, 8);

        // Reset in the middle of a run.
        start_cmd(5, 30, 30);
        obs(12, 1, -1, 0, 0, 0, 2);
        check("rst_mid_rd", r_rd[3], 0);
        check("rst_mid_mac", {r_st[3], r_vl[3]}, 0);
        check("rst_mid_busy", r_bz[3], 0);
        check("rst_mid_ready", r_rdy[3], 1);
        ov_late = 0;
        for (int k = 3; k < 12; k++) if (r_ov[k]) ov_late++;
        check("rst_mid_no_out", ov_late, 0);
        xmem[50] = 8'sd7;
        wmem[60] = -8'sd3;
        start_cmd(1, 50, 60);
        obs(8, 1, -1, 0, 0, 0, -1);
        check_cmd("after_rst", 1, 50, 60, 0);
        check("after_rst_literal", $signed(r_od[4]), relu_if(-21));

        // Randomized commands.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 12);
            bx  = $urandom_range(0, 255);
            bw  = $urandom_range(0, 255);
            start_cmd(len, bx, bw);
            obs(len + 6, 1, -1, 0, 0, 0, -1);
            check_cmd($sformatf("rand%0d", r), len, bx, bw, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
